// File: rtl/slv_guard_rst_ctrl_if.sv
// Purpose: reset handshake between slave guard, isolation block and subordinate reset.
// Latency: wires only; timing is owned by slv_guard_rst_ctrl.
// Backpressure: level-based request/status pair, no valid/ready or credits.
interface slv_guard_rst_ctrl_if;
    logic rst_req_i;
    logic rst_stat_o;
    logic isolate_o;
    logic isolated_i;
    logic slv_rst_no;
    logic busy_o;
    logic drain_timeout_o;

    // Reset controller side.
    modport slave (
        input  rst_req_i,
        input  isolated_i,
        output rst_stat_o,
        output isolate_o,
        output slv_rst_no,
        output busy_o,
        output drain_timeout_o
    );

    // Guard / isolation / subordinate side.
    modport master (
        output rst_req_i,
        output isolated_i,
        input  rst_stat_o,
        input  isolate_o,
        input  slv_rst_no,
        input  busy_o,
        input  drain_timeout_o
    );
endinterface

// File: rtl/slv_guard_rst_ctrl.sv
// Purpose: responder for the slave guard reset request; isolates, pulses and releases the subordinate reset.
// Latency: slv_rst_no falls 2 cycles after rst_req_i is sampled (isolated), rst_stat_o at 2+HoldCycles+SettleCycles.
// Backpressure: none; a started sequence always runs to DONE. Optional macro SLV_GUARD_RST_CTRL_CNT_EN adds rst_cnt_o.
module slv_guard_rst_ctrl #(
    parameter int unsigned DrainCycles  = 64,
    parameter int unsigned HoldCycles   = 16,
    parameter int unsigned SettleCycles = 8,
    parameter int unsigned CntWidth     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    slv_guard_rst_ctrl_if.slave  bus
`ifdef SLV_GUARD_RST_CTRL_CNT_EN
    ,
    output logic [7:0]           rst_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        ASSERT = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [CntWidth-1:0] DrainLast  = CntWidth'(DrainCycles - 1);
    localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    // State, phase counter and sticky drain-timeout flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: rst_req_i only matters in IDLE and DONE, so a sequence cannot be aborted half way.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.rst_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // isolated_i wins over a coincident timeout.
                if (bus.isolated_i) begin
                    state_d   = ASSERT;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else if (cnt_q == DrainLast) begin
                    state_d   = ASSERT;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q == HoldLast) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == SettleLast) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d = '0;
                if (!bus.rst_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the state register only; isolation holds through DONE until the guard drops its request.
    always_comb begin
        bus.rst_stat_o      = (state_q == DONE);
        bus.isolate_o       = (state_q != IDLE);
        bus.slv_rst_no      = (state_q != ASSERT);
        bus.busy_o          = (state_q != IDLE);
        bus.drain_timeout_o = timeout_q;
    end

`ifdef SLV_GUARD_RST_CTRL_CNT_EN
    logic [7:0] rst_cnt_q, rst_cnt_d;

    // Saturating count of completed sequences, bumped on DONE -> IDLE.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if ((state_q == DONE) && !bus.rst_req_i && (rst_cnt_q != 8'hFF)) begin
            rst_cnt_d = rst_cnt_q + 8'd1;
        end
    end

    // Completed-sequence counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rst_cnt_q <= 8'd0;
        end else begin
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign rst_cnt_o = rst_cnt_q;
`endif

endmodule

// File: doc/slv_guard_rst_ctrl.md
Name: slv_guard_rst_ctrl

Overview:
- Responder side of the slave guard reset handshake.
- Consumes the guard's reset request, isolates the guarded subordinate, and drives a timed active-low reset pulse into it.
- After release and settling, reports completion on the status line the guard uses to clear its reset request.
- Sits between the slave guard (rst_req / rst_stat) and the subordinate's reset input and the isolation logic on its AXI port.

Parameters:
- DrainCycles, 64: max cycles to wait for isolated_i before forcing reset; must be >= 1.
- HoldCycles, 16: cycles slv_rst_no is held low; must be >= 1.
- SettleCycles, 8: cycles after release before completion is reported; must be >= 1.
- CntWidth, 16: width of the internal cycle counter; must satisfy 2**CntWidth > max(DrainCycles, HoldCycles, SettleCycles).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- rst_req_i  in  1  reset request from slave guard, level
- rst_stat_o  out  1  reset complete, to guard reset_clear input, level
- isolate_o  out  1  request isolation of subordinate AXI port
- isolated_i  in  1  isolation block reports port quiescent
- slv_rst_no  out  1  reset to subordinate, active-low
- busy_o  out  1  sequence in progress (state != IDLE)
- drain_timeout_o  out  1  sticky: last drain ended by timeout rather than isolated_i

Behaviour:
- Single clock. All flops reset synchronously when rst_ni=0 is sampled on a rising clk_i edge.
- Reset values: state=IDLE, counter=0, rst_stat_o=0, isolate_o=0, slv_rst_no=1, busy_o=0, drain_timeout_o=0.
- All outputs are registered or decoded from the state register only, with no combinational path from inputs.
- FSM states: IDLE, DRAIN, ASSERT, SETTLE, DONE.
- IDLE:
  - All outputs at their reset values except drain_timeout_o, which holds.
  - rst_req_i=1 sampled → DRAIN next cycle; counter=0.
- DRAIN:
  - isolate_o=1, slv_rst_no=1.
  - isolated_i=1 → ASSERT; drain_timeout_o←0.
  - Else, counter==DrainCycles-1 → ASSERT; drain_timeout_o←1.
  - Else counter++.
  - If isolated_i and the timeout coincide, isolated_i wins: drain_timeout_o←0.
  - Counter is cleared on exit.
- ASSERT:
  - isolate_o=1, slv_rst_no=0 for exactly HoldCycles cycles.
  - Counter==HoldCycles-1 → SETTLE, counter←0.
- SETTLE:
  - isolate_o=1, slv_rst_no=1 for exactly SettleCycles cycles.
  - Then → DONE.
- DONE:
  - rst_stat_o=1, isolate_o=1, slv_rst_no=1.
  - Leave for IDLE once rst_req_i=0 is sampled; rst_stat_o=0 from that next cycle.
  - isolate_o stays high until rst_req_i falls, so the subordinate cannot see traffic before the guard has re-armed.
- rst_req_i deasserting in DRAIN, ASSERT or SETTLE is ignored; the sequence always runs to DONE. An aborted sequence would leave the subordinate half-reset.
- rst_req_i=1 in IDLE on the cycle directly after leaving DONE starts a new sequence; there is no dead cycle requirement.
- Latency, from the first cycle rst_req_i=1 is sampled in IDLE with isolated_i held high:
  - slv_rst_no falls 2 cycles later (1 cycle in DRAIN).
  - rst_stat_o rises at 2+HoldCycles+SettleCycles.
- Worst case, isolated_i never asserted: add DrainCycles-1.
- rst_ni=0 mid-sequence: immediate return to IDLE with slv_rst_no=1 on the next edge. A partially held subordinate reset is released; this is acceptable because a system reset also resets the subordinate.
- Counter arithmetic is unsigned, CntWidth bits, never wraps given the parameter constraint.

Optional Feature:
- Macro: SLV_GUARD_RST_CTRL_CNT_EN.
- When defined:
  - Adds output port rst_cnt_o, 8 bits.
  - Counts completed sequences: +1 on each DONE→IDLE transition.
  - Saturates at 255.
  - Reset value 0.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Nominal, Hold=16, Settle=8, isolated_i tied 1: pulse rst_req_i high at cycle 0 and hold it → slv_rst_no low for cycles 2..17; rst_stat_o high from cycle 26; drain_timeout_o=0. Drop rst_req_i at cycle 30 → state IDLE, rst_stat_o=0, isolate_o=0 from cycle 31.
- Drain timeout, DrainCycles=64, isolated_i tied 0 → slv_rst_no falls exactly 64 cycles after the first DRAIN cycle; drain_timeout_o=1 and sticky through IDLE until the next sequence sees isolated_i.
- Coincident isolated_i and timeout: assert isolated_i on the DrainCycles-1 cycle → ASSERT entered; drain_timeout_o=0.
- Early request drop: deassert rst_req_i during ASSERT → full HoldCycles pulse still produced; DONE is entered and exited to IDLE on the next cycle; rst_stat_o high for 1 cycle.
- Reset mid-sequence: rst_ni=0 for 1 cycle in ASSERT → next edge slv_rst_no=1, busy_o=0, rst_stat_o=0; with rst_req_i still 1, a new sequence starts the cycle after rst_ni returns to 1.
- With SLV_GUARD_RST_CTRL_CNT_EN defined: run 3 back-to-back sequences → rst_cnt_o=3. Force 300 sequences → rst_cnt_o=255.
